// File: rtl/ysyx_25040105_ifetch.sv
// Instruction fetch unit: issues one word-aligned read at a time, holds the
// returned instruction for decode, and follows control-flow redirects. A
// redirect that lands while a read is in flight marks that read to be dropped.
module ysyx_25040105_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_err,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] opc_q, opc_d;
  logic        err_q, err_d;
  logic        req_valid_q, req_valid_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  assign redirect_tgt        = {redirect_addr[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_addr[1:0];

  // Next-state: redirect wins over every handshake in every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect_en) pc_d = redirect_tgt;
      end
      StReq: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
          // Accepted read now targets a stale address; swallow its response.
          if (req_ready) begin
            state_d = StWait;
            drop_d  = 1'b1;
          end
        end else if (req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
          if (rsp_valid) begin
            state_d = StReq;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            inst_d  = rsp_data;
            opc_d   = pc_q;
            err_d   = rsp_err;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (redirect_en) begin
          pc_d    = redirect_tgt;
          state_d = StReq;
          if (out_ready) cnt_d = cnt_q + 32'd1;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
    req_valid_d = (state_d == StReq);
    out_valid_d = (state_d == StOut);
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= ResetPcAligned;
      drop_q      <= 1'b0;
      cnt_q       <= '0;
      inst_q      <= '0;
      opc_q       <= '0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      inst_q      <= inst_d;
      opc_q       <= opc_d;
      err_q       <= err_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = pc_q;
  assign out_valid = out_valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = opc_q;
  assign out_err   = err_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_25040105_ifetch.sv
// Bench for the fetch unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch protocol.
module tb_ysyx_25040105_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic        out_err;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  ysyx_25040105_ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .out_err      (out_err),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one fetch from REQ to OUT with immediate accept and response.
  task automatic fetch(input logic [31:0] data, input logic err);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    total++; if ({out_inst, out_pc, out_err} !== 65'd0) begin bad++;
      $display("FAIL rst_out_regs got %h %h %b want 0", out_inst, out_pc, out_err); end
    total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got %h want 0", fetch_cnt); end
    rst = 1'b0;
    step();  // IDLE -> REQ
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000) begin bad++;
      $display("FAIL first_req got %b %h want 1 80000000", req_valid, req_addr); end
  endtask

  task automatic test_basic();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL wait_req_valid got %b want 0", req_valid); end
    rsp_valid = 1'b1;
    rsp_data  = 32'h0010_0093;
    step();
    rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0010_0093
                 || out_err !== 1'b0) begin bad++;
      $display("FAIL basic_out got %b %h %h %b want 1 80000000 00100093 0",
               out_valid, out_pc, out_inst, out_err); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0004 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_next got %b %h %b want 1 80000004 0", req_valid, req_addr,
                      out_valid); end
    total++; if (fetch_cnt !== 32'd1) begin bad++; $display("FAIL basic_cnt got %h want 1", fetch_cnt); end
  endtask

  task automatic test_stall();
    fetch(32'h1234_5678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_inst !== 32'h1234_5678 || out_pc !== 32'h8000_0004
                   || req_valid !== 1'b0) begin bad++;
        $display("FAIL stall_hold[%0d] got %b %h %h %b want 1 12345678 80000004 0",
                 i, out_valid, out_inst, out_pc, req_valid); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (fetch_cnt !== 32'd2 || req_addr !== 32'h8000_0008) begin bad++;
      $display("FAIL stall_release got %h %h want 2 80000008", fetch_cnt, req_addr); end
  endtask

  task automatic test_redirect_wait();
    logic seen;
    seen = 1'b0;
    req_ready = 1'b1;
    step();
    req_ready     = 1'b0;
    redirect_en   = 1'b1;
    redirect_addr = 32'h8000_0102;
    step();
    redirect_en = 1'b0;
    seen |= out_valid;
    step();
    seen |= out_valid;
    step();
    seen |= out_valid;
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    seen |= out_valid;
    step();
    seen |= out_valid;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_out_valid got 1 want 0"); end
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0100) begin bad++;
      $display("FAIL drop_next_req got %b %h want 1 80000100", req_valid, req_addr); end
    total++; if (fetch_cnt !== 32'd2) begin bad++; $display("FAIL drop_cnt got %h want 2", fetch_cnt); end
  endtask

  task automatic test_redirect_out();
    fetch(32'h0000_0013, 1'b0);
    total++; if (out_pc !== 32'h8000_0100) begin bad++;
      $display("FAIL redir_out_pc got %h want 80000100", out_pc); end
    out_ready     = 1'b1;
    redirect_en   = 1'b1;
    redirect_addr = 32'h8000_0200;
    step();
    out_ready   = 1'b0;
    redirect_en = 1'b0;
    total++; if (fetch_cnt !== 32'd3 || out_valid !== 1'b0) begin bad++;
      $display("FAIL redir_out_cnt got %h %b want 3 0", fetch_cnt, out_valid); end
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0200) begin bad++;
      $display("FAIL redir_out_addr got %b %h want 1 80000200", req_valid, req_addr); end
  endtask

  task automatic test_err();
    fetch(32'h0, 1'b1);
    total++; if (out_err !== 1'b1 || out_inst !== 32'h0 || out_pc !== 32'h8000_0200) begin bad++;
      $display("FAIL err_set got %b %h %h want 1 0 80000200", out_err, out_inst, out_pc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    fetch(32'h0000_0013, 1'b0);
    total++; if (out_err !== 1'b0 || out_pc !== 32'h8000_0204) begin bad++;
      $display("FAIL err_clear got %b %h want 0 80000204", out_err, out_pc); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (fetch_cnt !== 32'd5) begin bad++; $display("FAIL err_cnt got %h want 5", fetch_cnt); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (req_valid !== 1'b0 || out_valid !== 1'b0 || fetch_cnt !== 32'd0) begin bad++;
      $display("FAIL mid_rst got %b %b %h want 0 0 0", req_valid, out_valid, fetch_cnt); end
    step();
    rst       = 1'b0;
    rsp_valid = 1'b1;  // stale response arriving in IDLE
    rsp_data  = 32'hBAD0_BAD0;
    step();
    total++; if (req_valid !== 1'b1 || req_addr !== 32'h8000_0000 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_req got %b %h %b want 1 80000000 0", req_valid, req_addr,
                      out_valid); end
    step();  // still stale, now in REQ without acceptance
    rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || req_valid !== 1'b1 || fetch_cnt !== 32'd0) begin bad++;
      $display("FAIL mid_rst_stale got %b %b %h want 0 1 0", out_valid, req_valid, fetch_cnt); end
  endtask

  // Randomized run. The model tracks transactions, not the DUT's state:
  // whether a read is in flight (and whether a redirect has doomed it), and
  // whether an instruction is being offered to decode.
  task automatic test_random();
    logic        boot, outstanding, doomed, held;
    logic [31:0] exp_pc, exp_cnt, txn_pc, held_inst, held_pc, tgt;
    logic        held_err, exp_req;
    int          delay;
    rst = 1'b1;
    step();
    rst = 1'b0;
    boot = 1'b1; outstanding = 1'b0; doomed = 1'b0; held = 1'b0; held_err = 1'b0;
    exp_pc = 32'h8000_0000; exp_cnt = 32'd0; txn_pc = '0; held_inst = '0; held_pc = '0;
    delay = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = !boot && !outstanding && !held;
      total++; if (req_valid !== exp_req) begin bad++;
        $display("FAIL rnd_req_valid cyc %0d got %b want %b", cyc, req_valid, exp_req); end
      total++; if (out_valid !== held) begin bad++;
        $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, out_valid, held); end
      if (exp_req) begin
        total++; if (req_addr !== exp_pc) begin bad++;
          $display("FAIL rnd_req_addr cyc %0d got %h want %h", cyc, req_addr, exp_pc); end
      end
      if (held) begin
        total++; if (out_inst !== held_inst || out_pc !== held_pc || out_err !== held_err) begin
          bad++; $display("FAIL rnd_out cyc %0d got %h %h %b want %h %h %b", cyc, out_inst,
                          out_pc, out_err, held_inst, held_pc, held_err); end
      end
      total++; if (fetch_cnt !== exp_cnt) begin bad++;
        $display("FAIL rnd_cnt cyc %0d got %h want %h", cyc, fetch_cnt, exp_cnt); end

      // Random inputs for the coming edge.
      redirect_en   = ($urandom_range(0, 7) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                  : $urandom;
      req_ready     = $urandom_range(0, 1);
      out_ready     = ($urandom_range(0, 4) < 3);
      rsp_data      = $urandom;
      rsp_err       = ($urandom_range(0, 3) == 0);
      if (outstanding) begin
        rsp_valid = (delay == 0);
        if (delay > 0) delay--;
      end else begin
        rsp_valid = ($urandom_range(0, 4) == 0);
      end
      tgt = redirect_addr & 32'hFFFF_FFFC;

      // Expected effect of the edge.
      if (boot) begin
        boot = 1'b0;
        if (redirect_en) exp_pc = tgt;
      end else if (outstanding) begin
        if (rsp_valid) begin
          outstanding = 1'b0;
          if (redirect_en || doomed) begin
            doomed = 1'b0;
          end else begin
            held = 1'b1; held_inst = rsp_data; held_pc = txn_pc; held_err = rsp_err;
          end
        end else if (redirect_en) begin
          doomed = 1'b1;
        end
        if (redirect_en) exp_pc = tgt;
      end else if (held) begin
        if (out_ready) exp_cnt++;
        if (redirect_en || out_ready) held = 1'b0;
        if (redirect_en) exp_pc = tgt;
        else if (out_ready) exp_pc = exp_pc + 32'd4;
      end else begin
        if (req_ready) begin
          outstanding = 1'b1;
          doomed      = redirect_en;
          txn_pc      = exp_pc;
          delay       = $urandom_range(0, 3);
        end
        if (redirect_en) exp_pc = tgt;
      end
      step();
    end
    redirect_en = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    out_ready = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
